// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline <-> trap/MRET sequencer signal bundle.
// master = pipeline/CSR side, slave = pipe_seq_ctrl. dbg_state exposes the FSM state.
interface pipe_seq_ctrl_if;
   logic       irq_req;
   logic       mie_en;
   logic       is_mretMW;
   logic       mem_busy;
   logic       reg_wrMW;
   logic [1:0] wb_selMW;
   logic [4:0] rdMW;
   logic [4:0] rs1F;
   logic [4:0] rs2F;
   logic       Stall_F;
   logic       Stall_MW;
   logic       Flush_MW;
   logic       trap_take;
   logic       mret_take;
   logic [1:0] pc_sel;
   logic [7:0] irq_cnt;
   logic [1:0] dbg_state;

   modport master (
      output irq_req, mie_en, is_mretMW, mem_busy, reg_wrMW, wb_selMW, rdMW, rs1F, rs2F,
      input  Stall_F, Stall_MW, Flush_MW, trap_take, mret_take, pc_sel, irq_cnt, dbg_state
   );

   modport slave (
      input  irq_req, mie_en, is_mretMW, mem_busy, reg_wrMW, wb_selMW, rdMW, rs1F, rs2F,
      output Stall_F, Stall_MW, Flush_MW, trap_take, mret_take, pc_sel, irq_cnt, dbg_state
   );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Interrupt/MRET sequencer for a two-stage (F, MW) pipeline: drains memory, takes traps, counts them.
// Optional macro LOAD_USE_STALL_EN adds load-use hazard stall/bubble generation.
module pipe_seq_ctrl (
   input  logic           clk,
   input  logic           rst,
   pipe_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      TRAP  = 2'd2,
      MRET  = 2'd3
   } state_t;

   localparam logic [1:0] PC_SEQ   = 2'b00;
   localparam logic [1:0] PC_MTVEC = 2'b01;
   localparam logic [1:0] PC_MEPC  = 2'b10;

   state_t     state;
   logic       trap_q;
   logic       mret_q;
   logic       flush_q;
   logic [1:0] pc_sel_q;
   logic [7:0] cnt_q;
   logic [7:0] cnt_inc;
   logic       irq_pend;
   logic       busy_stall;
   logic       lu_stall;

   assign irq_pend   = bus.irq_req & bus.mie_en;
   assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign busy_stall = ~rst & bus.mem_busy & ((state == IDLE) | (state == DRAIN));

`ifdef LOAD_USE_STALL_EN
   // Only in a quiet IDLE cycle: a pending trap/MRET wins, and a busy MW must hold rather than bubble.
   assign lu_stall = ~rst & (state == IDLE) & ~bus.is_mretMW & ~irq_pend & ~bus.mem_busy &
                     bus.reg_wrMW & (bus.wb_selMW == 2'b10) & (bus.rdMW != 5'd0) &
                     ((bus.rdMW == bus.rs1F) | (bus.rdMW == bus.rs2F));
`else
   logic unused_lu;
   assign unused_lu = ^{bus.reg_wrMW, bus.wb_selMW, bus.rdMW, bus.rs1F, bus.rs2F};
   assign lu_stall  = 1'b0;
`endif

   // Pulse outputs are registered alongside the state, so they are high exactly in TRAP/MRET.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt_q    <= 8'h00;
         trap_q   <= 1'b0;
         mret_q   <= 1'b0;
         flush_q  <= 1'b0;
         pc_sel_q <= PC_SEQ;
      end else begin
         trap_q   <= 1'b0;
         mret_q   <= 1'b0;
         flush_q  <= 1'b0;
         pc_sel_q <= PC_SEQ;
         case (state)
            IDLE: begin
               if (bus.is_mretMW) begin
                  state    <= MRET;
                  mret_q   <= 1'b1;
                  flush_q  <= 1'b1;
                  pc_sel_q <= PC_MEPC;
               end else if (irq_pend) begin
                  if (bus.mem_busy) begin
                     state <= DRAIN;
                  end else begin
                     state    <= TRAP;
                     trap_q   <= 1'b1;
                     flush_q  <= 1'b1;
                     pc_sel_q <= PC_MTVEC;
                     cnt_q    <= cnt_inc;
                  end
               end
            end
            DRAIN: begin
               // Committed: irq_req may drop, the trap is still taken once memory is free.
               if (!bus.mem_busy) begin
                  state    <= TRAP;
                  trap_q   <= 1'b1;
                  flush_q  <= 1'b1;
                  pc_sel_q <= PC_MTVEC;
                  cnt_q    <= cnt_inc;
               end
            end
            TRAP:    state <= IDLE;
            MRET:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Stall_F   = busy_stall | lu_stall;
   assign bus.Stall_MW  = busy_stall;
   assign bus.Flush_MW  = ~rst & (flush_q | lu_stall);
   assign bus.trap_take = ~rst & trap_q;
   assign bus.mret_take = ~rst & mret_q;
   assign bus.pc_sel    = rst ? PC_SEQ : pc_sel_q;
   assign bus.irq_cnt   = rst ? 8'h00 : cnt_q;
   assign bus.dbg_state = rst ? IDLE : state;
endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: irq_req  in  1  level-sensitive pending external interrupt.
REQ-004 SHALL have ports: mie_en  in  1  global machine interrupt enable (mstatus.MIE).
REQ-005 SHALL have ports: is_mretMW  in  1  MRET present in the MW stage.
REQ-006 SHALL have ports: mem_busy  in  1  data memory not ready, MW stage cannot retire.
REQ-007 SHALL have ports: reg_wrMW  in  1  MW-stage instruction writes the register file.
REQ-008 SHALL have ports: wb_selMW  in  2  MW writeback select; 2'b10 = load.
REQ-009 SHALL have ports: rdMW, rs1F, rs2F  in  5 each  MW destination register and F source registers.
REQ-010 SHALL have ports: Stall_F  out  1  hold PC and fetch register.
REQ-011 SHALL have ports: Stall_MW  out  1  hold MW pipeline register.
REQ-012 SHALL have ports: Flush_MW  out  1  load a bubble (reg_wr=0, csr_wr=0) into MW.
REQ-013 SHALL have ports: trap_take  out  1  one-cycle pulse; CSR file saves mepc/mcause and clears MIE.
REQ-014 SHALL have ports: mret_take  out  1  one-cycle pulse; CSR file restores MIE.
REQ-015 SHALL have ports: pc_sel  out  2  00 sequential/branch, 01 mtvec, 10 mepc.
REQ-016 SHALL have ports: irq_cnt  out  8  count of taken traps, saturating at 8'hFF.

Function
REQ-017 SHALL implement FSM states IDLE, DRAIN, TRAP and MRET, held in a registered state variable.
REQ-018 In IDLE, is_mretMW=1 SHALL transition to MRET; MRET has priority over an interrupt in the same cycle.
REQ-019 In IDLE, irq_req & mie_en with is_mretMW=0 SHALL transition to TRAP if mem_busy=0, else to DRAIN.
REQ-020 DRAIN SHALL assert Stall_F=1 and Stall_MW=1 while mem_busy=1, and SHALL go to TRAP on the first cycle mem_busy=0.
REQ-021 DRAIN SHALL ignore irq_req deassertion; once entered, the trap is committed.
REQ-022 TRAP SHALL last exactly one cycle with trap_take=1, Flush_MW=1, pc_sel=01 and Stall_F=0, then return to IDLE.
REQ-023 MRET SHALL last exactly one cycle with mret_take=1, Flush_MW=1, pc_sel=10 and Stall_F=0, then return to IDLE.
REQ-024 In IDLE, mem_busy=1 SHALL assert Stall_F=1 and Stall_MW=1 combinationally in the same cycle.
REQ-025 In IDLE, all outputs not named above SHALL be 0, and pc_sel SHALL be 00.
REQ-026 Interrupt-to-trap_take latency SHALL be 1 cycle with mem_busy=0, and 1+N cycles for N busy cycles.
REQ-027 irq_cnt SHALL increment by 1 on each TRAP cycle and SHALL hold at 8'hFF without wrapping.
REQ-028 After TRAP, a further trap SHALL be taken only when mie_en=1 is sampled again in IDLE.
REQ-029 trap_take and mret_take SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=1 SHALL force state=IDLE and irq_cnt=0 on the next rising clk edge.
REQ-031 While rst=1, all outputs SHALL be 0 and pc_sel SHALL be 00.
REQ-032 Reset asserted in DRAIN, TRAP or MRET SHALL abort the sequence with no trap_take or mret_take pulse.

Configuration
REQ-033 Macro LOAD_USE_STALL_EN SHALL control load-use hazard handling.
REQ-034 With LOAD_USE_STALL_EN defined, a load-use hazard is IDLE with reg_wrMW=1, wb_selMW=2'b10, rdMW≠0 and rdMW equal to rs1F or rs2F.
REQ-035 With LOAD_USE_STALL_EN defined, a load-use hazard SHALL assert Stall_F=1 and Flush_MW=1 for one cycle.
REQ-036 With LOAD_USE_STALL_EN defined, an interrupt SHALL take precedence over a load-use hazard in the same cycle.
REQ-037 Without LOAD_USE_STALL_EN, no load-use logic SHALL exist, and Stall_F/Flush_MW SHALL depend only on the FSM and mem_busy.

Verification
REQ-038 rst held 2 cycles, then released -> state IDLE, all outputs 0, irq_cnt=0.
REQ-039 irq_req=1, mie_en=1, mem_busy=0 -> next cycle trap_take=1, pc_sel=01, Flush_MW=1, irq_cnt=1; following cycle IDLE.
REQ-040 irq_req=1 with mem_busy=1 for 3 cycles -> Stall_F=Stall_MW=1 for 3 cycles, trap_take on the 4th cycle.
REQ-041 is_mretMW=1 and irq_req=1 in the same cycle -> mret_take=1, pc_sel=10 first; trap follows only if mie_en=1 afterwards.
REQ-042 260 back-to-back traps -> irq_cnt saturates at 8'hFF.
REQ-043 LOAD_USE_STALL_EN defined; wb_selMW=10, rdMW=5, rs2F=5 -> one cycle of Stall_F=1, Flush_MW=1; with rdMW=0 -> no stall.
